// File: rtl/oam_dma_ctrl.sv
// oam_dma_ctrl
//   Game Boy OAM DMA sequencer and CPU/DMA arbiter for the shared memory bus.
//   A CPU write to FF46 latches the source page and copies LEN bytes from
//   {src_hi,8'h00} into OAM. Each byte takes CPB clocks:
//     - phase 0 reads the source byte;
//     - phase 1 writes it into OAM;
//     - the remaining phases leave the bus to the CPU.
//
// Ports
//   clk, rst_n            clock (rising edge), async active-low reset
//   cpu_addr/wdata/we/re  CPU bus request (strobes last one clock)
//   cpu_rdata             read data, valid the clock after an accepted cpu_re
//   cpu_wait              CPU must hold its request this clock
//   mem_addr/wdata/we/re  shared memory bus, mem_rdata valid 1 clock after mem_re
//   oam_addr/wdata/we     OAM byte write port
//   dma_active            transfer in progress, start delay included
//
// Build option
//   OAM_DMA_BUS_LOCK_EN   when defined, CPU accesses below FF00 are blocked while
//                         dma_active (reads return 8'hFF, writes dropped, no wait).
//                         When undefined, they pass through like FFxx accesses.

module oam_dma_ctrl #(
    parameter int unsigned LEN         = 160,
    parameter int unsigned CPB         = 4,
    parameter int unsigned START_DELAY = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    input  logic        cpu_we,
    input  logic        cpu_re,
    output logic [7:0]  cpu_rdata,
    output logic        cpu_wait,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_wdata,
    output logic        mem_we,
    output logic        mem_re,
    input  logic [7:0]  mem_rdata,
    output logic [7:0]  oam_addr,
    output logic [7:0]  oam_wdata,
    output logic        oam_we,
    output logic        dma_active
);

    localparam int unsigned PW = $clog2(CPB);
    localparam int unsigned DW = (START_DELAY > 1) ? $clog2(START_DELAY) : 1;
    localparam logic [7:0]    LAST_IDX = 8'(LEN - 1);
    localparam logic [PW-1:0] LAST_PH  = PW'(CPB - 1);
    localparam logic [DW-1:0] LAST_DLY = (START_DELAY > 0) ? DW'(START_DELAY - 1) : '0;

    typedef enum logic [1:0] {IDLE, DELAY, XFER} state_t;

    state_t        state;
    logic [7:0]    dma_reg;
    logic [7:0]    byte_idx;
    logic [PW-1:0] phase;
    logic [DW-1:0] dly_cnt;
    logic          rd_from_mem;
    logic [7:0]    rd_val;

    logic       cpu_req, cpu_hi, is_ff46, dma_slot, cpu_blocked;
    logic       ff46_wr;
    logic [7:0] src_hi;

    always_comb begin
        cpu_req  = cpu_we | cpu_re;
        cpu_hi   = (cpu_addr >= 16'hFF00);
        is_ff46  = (cpu_addr == 16'hFF46);
        dma_slot = (state == XFER) && (phase == '0);
`ifdef OAM_DMA_BUS_LOCK_EN
        cpu_blocked = dma_active && !cpu_hi;
        cpu_wait    = cpu_req && dma_slot && cpu_hi;
`else
        cpu_blocked = 1'b0;
        cpu_wait    = cpu_req && dma_slot;
`endif
        ff46_wr = cpu_we && is_ff46 && !cpu_wait;
        // Echo RAM pages E0..FF fold down onto WRAM
        src_hi  = (dma_reg >= 8'hE0) ? (dma_reg - 8'h20) : dma_reg;

        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
        mem_we    = 1'b0;
        mem_re    = 1'b0;
        if (dma_slot) begin
            mem_addr  = {src_hi, byte_idx};
            mem_wdata = '0;
            mem_re    = 1'b1;
        end else if (!cpu_blocked && !is_ff46) begin
            mem_we = cpu_we;
            mem_re = cpu_re;
        end

        // An FF46 write landing on phase 1 restarts the copy, so its byte is dropped
        oam_we    = (state == XFER) && (phase == PW'(1)) && !ff46_wr;
        oam_addr  = byte_idx;
        oam_wdata = oam_we ? mem_rdata : '0;

        cpu_rdata = rd_from_mem ? mem_rdata : rd_val;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            dma_reg     <= 8'hFF;
            byte_idx    <= '0;
            phase       <= '0;
            dly_cnt     <= '0;
            dma_active  <= 1'b0;
            rd_from_mem <= 1'b0;
            rd_val      <= 8'hFF;
        end else begin
            rd_from_mem <= 1'b0;
            if (cpu_re && !cpu_wait) begin
                if (is_ff46)
                    rd_val <= dma_reg;
                else if (cpu_blocked)
                    rd_val <= 8'hFF;
                else
                    rd_from_mem <= 1'b1;
            end

            if (ff46_wr) begin
                dma_reg    <= cpu_wdata;
                byte_idx   <= '0;
                phase      <= '0;
                dly_cnt    <= '0;
                dma_active <= 1'b1;
                state      <= (START_DELAY == 0) ? XFER : DELAY;
            end else begin
                case (state)
                    IDLE: begin
                        // FSM leaves XFER after the last OAM write; dma_active
                        // covers the remaining bus-free phases of that byte.
                        if (dma_active) begin
                            if (phase == LAST_PH) begin
                                phase      <= '0;
                                dma_active <= 1'b0;
                            end else begin
                                phase <= phase + PW'(1);
                            end
                        end
                    end
                    DELAY: begin
                        if (dly_cnt == LAST_DLY) begin
                            dly_cnt <= '0;
                            state   <= XFER;
                        end else begin
                            dly_cnt <= dly_cnt + DW'(1);
                        end
                    end
                    XFER: begin
                        if (phase == PW'(1) && byte_idx == LAST_IDX) begin
                            state    <= IDLE;
                            byte_idx <= '0;
                            if (CPB == 2) begin
                                phase      <= '0;
                                dma_active <= 1'b0;
                            end else begin
                                phase <= PW'(2);
                            end
                        end else if (phase == LAST_PH) begin
                            phase    <= '0;
                            byte_idx <= byte_idx + 8'd1;
                        end else begin
                            phase <= phase + PW'(1);
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_oam_dma_ctrl.sv
module tb_oam_dma_ctrl;

    localparam int LEN = 160;
    localparam int CPB = 4;
    localparam int SD  = 4;
    localparam int ACTIVE_CLKS = SD + LEN * CPB;

    logic        clk, rst_n;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic        cpu_we, cpu_re;
    logic [7:0]  cpu_rdata;
    logic        cpu_wait;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_we, mem_re;
    logic [7:0]  mem_rdata;
    logic [7:0]  oam_addr, oam_wdata;
    logic        oam_we, dma_active;

    oam_dma_ctrl #(.LEN(LEN), .CPB(CPB), .START_DELAY(SD)) dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_we(cpu_we), .cpu_re(cpu_re),
        .cpu_rdata(cpu_rdata), .cpu_wait(cpu_wait),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
        .mem_rdata(mem_rdata),
        .oam_addr(oam_addr), .oam_wdata(oam_wdata), .oam_we(oam_we),
        .dma_active(dma_active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory contents are fixed at start; CPU writes are not folded back in.
    logic [7:0] mem_m [0:65535];
    logic [7:0] oam_m [0:255];
    int oam_addr_q[$];
    int rd_addr_q[$];

    always @(posedge clk) begin
        if (mem_re) begin
            mem_rdata <= mem_m[mem_addr];
            rd_addr_q.push_back(int'(mem_addr));
        end
        if (oam_we) begin
            oam_m[oam_addr] <= oam_wdata;
            oam_addr_q.push_back(int'(oam_addr));
        end
    end

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cpu_idle();
        cpu_we = 1'b0;
        cpu_re = 1'b0;
    endtask

    // Drives an FF46 write and holds it through any wait; returns inside the accepting clock.
    task automatic ff46_write(input logic [7:0] v, output int waits);
        cpu_addr  = 16'hFF46;
        cpu_wdata = v;
        cpu_we    = 1'b1;
        cpu_re    = 1'b0;
        #1;
        waits = 0;
        while (cpu_wait && waits < 8) begin
            @(negedge clk); #1;
            waits++;
        end
    endtask

    task automatic cpu_read(input logic [15:0] a, output logic [7:0] d, output int waits);
        cpu_addr = a;
        cpu_we   = 1'b0;
        cpu_re   = 1'b1;
        #1;
        waits = 0;
        while (cpu_wait && waits < 8) begin
            @(negedge clk); #1;
            waits++;
        end
        @(negedge clk);
        cpu_re = 1'b0;
        #1;
        d = cpu_rdata;
    endtask

    task automatic run_xfer(output int n);
        n = 0;
        while (dma_active && n < 5000) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (dma_active && n < 5000) begin
            n++;
            @(negedge clk);
        end
        check(tag, 32'(n < 5000), 32'd1);
    endtask

    task automatic wait_oam(input int idx, output bit ok);
        int n = 0;
        ok = 1'b0;
        while (!ok && n < 5000) begin
            @(negedge clk); #1;
            n++;
            if (oam_we && int'(oam_addr) == idx) ok = 1'b1;
        end
    endtask

    // Expected transfer derived directly from the page rule and the memory image
    task automatic verify(input string tag, input logic [7:0] reg_v, input int rb, input int ob);
        int base, bad_rd, bad_seq, bad_data;
        logic [7:0] hi;
        hi = (reg_v >= 8'hE0) ? 8'(reg_v - 8'h20) : reg_v;
        base = int'(hi) * 256;
        bad_rd = 0; bad_seq = 0; bad_data = 0;
        check({tag, "_nreads"},  32'(rd_addr_q.size() - rb),  32'(LEN));
        check({tag, "_nwrites"}, 32'(oam_addr_q.size() - ob), 32'(LEN));
        for (int i = 0; i < LEN; i++) begin
            if (rb + i >= rd_addr_q.size() || rd_addr_q[rb + i] != base + i) bad_rd++;
            if (ob + i >= oam_addr_q.size() || oam_addr_q[ob + i] != i) bad_seq++;
            if (oam_m[i] !== mem_m[base + i]) bad_data++;
        end
        check({tag, "_src_addrs"}, 32'(bad_rd),   32'd0);
        check({tag, "_oam_addrs"}, 32'(bad_seq),  32'd0);
        check({tag, "_oam_data"},  32'(bad_data), 32'd0);
    endtask

    initial begin
        logic [7:0]  d, v;
        logic [15:0] a;
        int w, n, rb, ob;
        bit ok;

        for (int i = 0; i < 65536; i++) mem_m[i] = 8'($urandom);
        rst_n = 1'b0; cpu_addr = '0; cpu_wdata = '0; cpu_we = 1'b0; cpu_re = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk); #1;

        // Reset state
        check("rst_dma_active", 32'(dma_active), 32'd0);
        check("rst_oam_we",     32'(oam_we),     32'd0);
        check("rst_oam_addr",   32'(oam_addr),   32'd0);
        check("rst_oam_wdata",  32'(oam_wdata),  32'd0);
        check("rst_cpu_wait",   32'(cpu_wait),   32'd0);
        check("rst_cpu_rdata",  32'(cpu_rdata),  32'hFF);

        // Passthrough when idle
        a = 16'($urandom_range(0, 16'hFEFF));
        cpu_addr = a; cpu_re = 1'b1; #1;
        check("idle_mem_addr", 32'(mem_addr), 32'(a));
        check("idle_mem_re",   32'(mem_re),   32'd1);
        @(negedge clk); cpu_idle(); #1;
        check("idle_rdata", 32'(cpu_rdata), 32'(mem_m[a]));
        cpu_addr = 16'hFF46; cpu_re = 1'b1; #1;
        check("ff46_rd_not_fwd", 32'(mem_re), 32'd0);
        @(negedge clk); cpu_idle(); #1;
        check("ff46_rd_reset", 32'(cpu_rdata), 32'hFF);

        // Test 1: FF46=C1
        ff46_write(8'hC1, w);
        rb = rd_addr_q.size(); ob = oam_addr_q.size();
        check("t1_ff46_no_fwd", 32'(mem_we), 32'd0);
        @(negedge clk); cpu_idle();
        run_xfer(n);
        check("t1_active_clks", 32'(n), 32'(ACTIVE_CLKS));
        verify("t1", 8'hC1, rb, ob);

        // Test 2: FF46=E3 (echo page), register readback
        ff46_write(8'hE3, w);
        rb = rd_addr_q.size(); ob = oam_addr_q.size();
        @(negedge clk); cpu_idle();
        cpu_read(16'hFF46, d, w);
        check("t2_ff46_delay", 32'(d), 32'hE3);
        repeat (100) @(negedge clk);
        cpu_read(16'hFF46, d, w);
        check("t2_ff46_during", 32'(d), 32'hE3);
        wait_idle("t2_finish");
        cpu_read(16'hFF46, d, w);
        check("t2_ff46_after", 32'(d), 32'hE3);
        verify("t2", 8'hE3, rb, ob);

        // Random source pages
        for (int k = 0; k < 2; k++) begin
            v = 8'($urandom_range(0, 255));
            ff46_write(v, w);
            rb = rd_addr_q.size(); ob = oam_addr_q.size();
            @(negedge clk); cpu_idle();
            run_xfer(n);
            check("rnd_active_clks", 32'(n), 32'(ACTIVE_CLKS));
            verify("rnd", v, rb, ob);
        end

        // Tests 3/4: CPU traffic during a transfer from page 40
        ff46_write(8'h40, w);
        @(negedge clk); cpu_idle();
        wait_oam(5, ok);
        check("t3_found_byte5", 32'(ok), 32'd1);
        @(negedge clk);                          // phase 2
        cpu_addr = 16'hFF90; cpu_wdata = 8'h5A; cpu_we = 1'b1; #1;
        check("t3_hram_wait",  32'(cpu_wait),  32'd0);
        check("t3_hram_we",    32'(mem_we),    32'd1);
        check("t3_hram_addr",  32'(mem_addr),  32'hFF90);
        check("t3_hram_wdata", 32'(mem_wdata), 32'h5A);
        @(negedge clk);                          // phase 3
        cpu_we = 1'b0; cpu_addr = 16'h8000; cpu_re = 1'b1; #1;
        check("t3_rd8000_wait", 32'(cpu_wait), 32'd0);
`ifdef OAM_DMA_BUS_LOCK_EN
        check("t3_rd8000_re", 32'(mem_re), 32'd0);
`else
        check("t3_rd8000_re", 32'(mem_re), 32'd1);
`endif
        @(negedge clk);                          // phase 0 of byte 6
        cpu_re = 1'b0; cpu_addr = 16'hC000; cpu_wdata = 8'h55; cpu_we = 1'b1; #1;
`ifdef OAM_DMA_BUS_LOCK_EN
        check("t3_rd8000_data", 32'(cpu_rdata), 32'hFF);
        check("t3_wrC000_wait", 32'(cpu_wait),  32'd0);
`else
        check("t3_rd8000_data", 32'(cpu_rdata), 32'(mem_m[16'h8000]));
        check("t3_wrC000_wait", 32'(cpu_wait),  32'd1);
`endif
        check("t3_wrC000_we_p0", 32'(mem_we), 32'd0);
        @(negedge clk); #1;                      // phase 1, write still held
`ifdef OAM_DMA_BUS_LOCK_EN
        check("t3_wrC000_we_p1", 32'(mem_we), 32'd0);
`else
        check("t3_wrC000_we_p1", 32'(mem_we), 32'd1);
`endif
        cpu_idle();
        wait_oam(20, ok);
        check("t4_found_byte20", 32'(ok), 32'd1);
        repeat (CPB - 1) @(negedge clk);         // phase 0 of byte 21
        cpu_addr = 16'hFF80; cpu_re = 1'b1; #1;
        check("t4_p0_wait",   32'(cpu_wait), 32'd1);
        check("t4_p0_re",     32'(mem_re),   32'd1);
        check("t4_p0_addr",   32'(mem_addr), 32'h4015);
        @(negedge clk); #1;
        check("t4_p1_wait",   32'(cpu_wait), 32'd0);
        check("t4_p1_addr",   32'(mem_addr), 32'hFF80);
        check("t4_p1_re",     32'(mem_re),   32'd1);
        @(negedge clk); cpu_idle(); #1;
        check("t4_rdata", 32'(cpu_rdata), 32'(mem_m[16'hFF80]));
        wait_idle("t34_finish");

        // Test 5: restart at byte 50 with D0
        ff46_write(8'h12, w);
        @(negedge clk); cpu_idle();
        wait_oam(49, ok);
        check("t5_found_byte49", 32'(ok), 32'd1);
        repeat (CPB - 1) @(negedge clk);         // phase 0 of byte 50
        ff46_write(8'hD0, w);
        check("t5_restart_waits", 32'(w), 32'd1);
        check("t5_suppress_oam",  32'(oam_we), 32'd0);
        check("t5_last_before",   32'(oam_addr_q[oam_addr_q.size() - 1]), 32'd49);
        rb = rd_addr_q.size(); ob = oam_addr_q.size();
        @(negedge clk); cpu_idle();
        run_xfer(n);
        check("t5_active_clks", 32'(n), 32'(ACTIVE_CLKS));
        verify("t5", 8'hD0, rb, ob);

        // Test 6: async reset at byte 80
        ff46_write(8'h77, w);
        @(negedge clk); cpu_idle();
        wait_oam(80, ok);
        check("t6_found_byte80", 32'(ok), 32'd1);
        rst_n = 1'b0; #1;
        check("t6_rst_active", 32'(dma_active), 32'd0);
        check("t6_rst_oam_we", 32'(oam_we),     32'd0);
        @(negedge clk); rst_n = 1'b1; #1;
        cpu_read(16'hFF46, d, w);
        check("t6_ff46_reset", 32'(d), 32'hFF);
        cpu_addr = 16'hC000; cpu_wdata = 8'hAB; cpu_we = 1'b1; #1;
        check("t6_pt_we",    32'(mem_we),    32'd1);
        check("t6_pt_addr",  32'(mem_addr),  32'hC000);
        check("t6_pt_wdata", 32'(mem_wdata), 32'hAB);
        @(negedge clk); cpu_idle();
        a = 16'($urandom_range(0, 16'hFEFF));
        cpu_read(a, d, w);
        check("t6_pt_rdata", 32'(d), 32'(mem_m[a]));
        check("t6_pt_active", 32'(dma_active), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
